rr_resource_arbiter: RTL and testbench

- Shares one resource among N requesters using the req -> grant -> use -> release protocol of the resource/granter pair.
- Round-robin arbitration; exactly one grant outstanding at a time.
- Sits between the requester FSMs and the shared resource.
- Watchdog revokes a grant held too long; protocol-violation flags exist for property checkers.

---
 rtl/rr_resource_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_resource_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// The use/release inputs are named use_i/release_i: both plain names are SV keywords.
module rr_resource_arbiter #(
  parameter int N        = 4,
  parameter int IW       = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  use_i,
  input  logic [N-1:0]  release_i,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic          timeout,
  output logic          violation
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RECOVER
  } state_t;

  localparam logic [CW-1:0] HMAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HLIM = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic          viol_q, viol_d;

  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] ptr_nxt;
  logic [N-1:0]  owner_oh;
  logic [N-1:0]  sel_oh;

  // First requester at or after ptr, wrapping mod N.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign owner_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;
  assign sel_oh   = {{(N-1){1'b0}}, 1'b1} << sel;
  assign ptr_nxt  = (owner_q == LAST) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    viol_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        viol_d = (|use_i) || (|release_i);
        if (found) begin
          state_d = BUSY;
          grant_d = sel_oh;
          owner_d = sel;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      BUSY: begin
        viol_d = (|((use_i | release_i) & ~owner_oh))
              || (release_i[owner_q] && use_i[owner_q]);
        if (hold_q != HMAX) hold_d = hold_q + CW'(1);
        // Release takes priority over the watchdog.
        if (release_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_nxt;
        end else if (hold_q == HLIM) begin
          state_d   = RECOVER;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = ptr_nxt;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      viol_q    <= viol_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign violation = viol_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter: vector table plus
// hand-written timeout, release-vs-timeout and async reset sequences.
module tb_rr_resource_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, use_i, rel;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy, timeout, violation;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] r;
    logic [3:0] u;
    logic [3:0] l;
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic       t;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  rr_resource_arbiter #(
    .N(4), .IW(2), .MAX_HOLD(16), .CW(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .use_i    (use_i),
    .release_i(rel),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .timeout  (timeout),
    .violation(violation)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string f,
                     input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s.%s got=%0h exp=%0h", nm, f, a, e);
    end
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g,
                            input logic [1:0] o, input logic b,
                            input logic t, input logic v);
    cmp(nm, "grant", 32'(grant), 32'(g));
    if (b) cmp(nm, "owner", 32'(owner), 32'(o));
    cmp(nm, "busy", 32'(busy), 32'(b));
    cmp(nm, "timeout", 32'(timeout), 32'(t));
    cmp(nm, "violation", 32'(violation), 32'(v));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] u,
                      input logic [3:0] l);
    @(negedge clk);
    req = r; use_i = u; rel = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // r, u, l -> grant, owner, busy, timeout, violation
    vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1, 0, 0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1, 0, 0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1, 0, 0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0010, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0100, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b1000, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b0000, 4'b0010, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b1001, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1, 0, 0});
    vecs.push_back('{4'b1001, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1, 0, 0});
    vecs.push_back('{4'b1001, 4'b0000, 4'b1000, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b1001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0});
    vecs.push_back('{4'b1001, 4'b0000, 4'b0100, 4'b0001, 2'd0, 1, 0, 1});
    vecs.push_back('{4'b1001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0});
    vecs.push_back('{4'b1001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0});
    vecs.push_back('{4'b1001, 4'b0010, 4'b0000, 4'b0001, 2'd0, 1, 0, 1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0, 0});
    vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, 0, 1});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0});

    rst = 1'b1; req = '0; use_i = '0; rel = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    cmp("reset", "owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].u, vecs[i].l);
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].o,
                 vecs[i].b, vecs[i].t, vecs[i].v);
    end

    // Watchdog: requester 2 never releases; 3 waits behind it.
    step(4'b0100, 4'b0000, 4'b0000);
    expect_out("to_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step(4'b1100, 4'b0100, 4'b0000);
      expect_out($sformatf("to_hold%0d", k), 4'b0100, 2'd2,
                 1'b1, 1'b0, 1'b0);
    end
    step(4'b1100, 4'b0000, 4'b0000);
    expect_out("to_fire", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    step(4'b1000, 4'b0000, 4'b0000);
    expect_out("to_recover", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 4'b0000, 4'b0000);
    expect_out("to_next", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);

    // Release on the watchdog's last cycle beats the timeout.
    for (int k = 1; k < 16; k++) begin
      step(4'b0000, 4'b0000, 4'b0000);
      expect_out($sformatf("rt_hold%0d", k), 4'b1000, 2'd3,
                 1'b1, 1'b0, 1'b0);
    end
    step(4'b0000, 4'b0000, 4'b1000);
    expect_out("rt_release", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000);
    expect_out("rt_regrant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while busy.
    @(negedge clk);
    req = 4'b0001;
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0100;
    @(posedge clk);
    #1;
    expect_out("arst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
